// File: rtl/branch_predictor_btb.sv
// Branch predictor with branch target buffer.
// Direct-mapped table of tagged entries holding a saturating direction counter
// and a stored target. Fetch reads the table combinationally and execute trains it.
// After reset a sequencer clears the table one entry per cycle before lookups
// and updates are honoured. Two saturating statistics counters track resolved
// branches and mispredictions.
module branch_predictor_btb #(
    parameter int XLEN         = 32,
    parameter int ENTRIES      = 64,
    parameter int TAG_BITS     = 8,
    parameter int CTR_BITS     = 2,
    parameter int PREDICT_MODE = 1
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    input  logic            update_mispredict,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int IDX = $clog2(ENTRIES);
    localparam logic [IDX-1:0]      INIT_LAST = IDX'(ENTRIES - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX   = '1;
    localparam logic [CTR_BITS-1:0] CTR_WEAK  = CTR_BITS'(1) << (CTR_BITS - 1);

    typedef enum logic {ST_INIT, ST_RUN} state_t;

    state_t          state_q, state_d;
    logic [IDX-1:0]  init_idx_q;

    logic                valid_q  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q    [ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
    logic [XLEN-1:0]     target_q [ENTRIES];

    logic [IDX-1:0]      lookup_idx, upd_idx;
    logic [TAG_BITS-1:0] lookup_tag, upd_tag;
    logic                upd_en, upd_hit;
    logic                unused_pc_bits;

    assign lookup_idx = lookup_pc[IDX+1:2];
    assign lookup_tag = lookup_pc[IDX+2+TAG_BITS-1:IDX+2];
    assign upd_idx    = update_pc[IDX+1:2];
    assign upd_tag    = update_pc[IDX+2+TAG_BITS-1:IDX+2];

    // Byte-offset and above-tag PC bits take no part in indexing or matching.
    assign unused_pc_bits = ^{lookup_pc[1:0], update_pc[1:0],
                              lookup_pc >> (IDX + 2 + TAG_BITS),
                              update_pc >> (IDX + 2 + TAG_BITS)};

    // State register and clear-sequencer index; reset restarts the clear from entry 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= ST_INIT;
            init_idx_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_INIT) begin
                init_idx_q <= init_idx_q + IDX'(1);
            end
        end
    end

    // Next-state and ready decode: leave INIT after the last entry is cleared.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_INIT: if (init_idx_q == INIT_LAST) state_d = ST_RUN;
            ST_RUN:  ready = 1'b1;
            default: state_d = ST_INIT;
        endcase
    end

    // Combinational lookup; reads see the table before any same-cycle update.
    always_comb begin
        pred_hit    = ready && valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
        pred_taken  = pred_hit && ctr_q[lookup_idx][CTR_BITS-1] && (PREDICT_MODE == 1);
        pred_target = pred_hit ? target_q[lookup_idx] : '0;
    end

    assign upd_en  = update_valid && ready && !reset;
    assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

    // Table write port: clear one entry per cycle in INIT, train on resolved branches in RUN.
    always_ff @(posedge clk) begin
        // NOTE: the table has no reset term; the sequencer clears valid/ctr
        // after reset, and tag/target are don't-care while an entry is invalid.
        if (state_q == ST_INIT) begin
            valid_q[init_idx_q] <= 1'b0;
            ctr_q[init_idx_q]   <= '0;
        end else if (upd_en) begin
            if (upd_hit) begin
                if (update_taken) begin
                    if (ctr_q[upd_idx] != CTR_MAX) ctr_q[upd_idx] <= ctr_q[upd_idx] + CTR_BITS'(1);
                    target_q[upd_idx] <= update_target;
                end else if (ctr_q[upd_idx] != '0) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - CTR_BITS'(1);
                end
            end else if (update_taken) begin
                valid_q[upd_idx]  <= 1'b1;
                tag_q[upd_idx]    <= upd_tag;
                target_q[upd_idx] <= update_target;
                ctr_q[upd_idx]    <= CTR_WEAK;
            end
        end
    end

    // Saturating statistics; only updates honoured in RUN are counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (upd_en) begin
            if (branch_count != '1) branch_count <= branch_count + 32'd1;
            if (update_mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Testbench for branch_predictor_btb: a counter-mode and a static-mode instance
// share all inputs; vectors are pushed to a scoreboard and compared after each edge.
module tb_branch_predictor_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic        update_mispredict;

    logic        ready1, hit1, taken1;
    logic [31:0] target1, bc1, mc1;
    logic        ready0, hit0, taken0;
    logic [31:0] target0, bc0, mc0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_predictor_btb #(.PREDICT_MODE(1)) dut_m1 (
        .clk(clk), .reset(reset), .ready(ready1), .lookup_pc(lookup_pc),
        .pred_hit(hit1), .pred_taken(taken1), .pred_target(target1),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .branch_count(bc1), .mispredict_count(mc1)
    );

    branch_predictor_btb #(.PREDICT_MODE(0)) dut_m0 (
        .clk(clk), .reset(reset), .ready(ready0), .lookup_pc(lookup_pc),
        .pred_hit(hit0), .pred_taken(taken0), .pred_target(target0),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .branch_count(bc0), .mispredict_count(mc0)
    );

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        umis;
        logic [31:0] lpc;
        logic        hit;
        logic        tkn;
        logic [31:0] tgt;
        logic [31:0] bc;
        logic [31:0] mc;
    } step_t;

    step_t steps [16];
    step_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Lookup checks on both instances; the static instance never predicts taken.
    task automatic check_lookup(input string name, input logic hit, input logic tkn,
                                input logic [31:0] tgt);
        check({name, "_m1_hit"},    32'(hit1),    32'(hit));
        check({name, "_m1_taken"},  32'(taken1),  32'(tkn));
        check({name, "_m1_target"}, target1,      tgt);
        check({name, "_m0_hit"},    32'(hit0),    32'(hit));
        check({name, "_m0_taken"},  32'(taken0),  32'(1'b0));
        check({name, "_m0_target"}, target0,      tgt);
    endtask

    task automatic check_counts(input string name, input logic [31:0] bc, input logic [31:0] mc);
        check({name, "_m1_bc"}, bc1, bc);
        check({name, "_m1_mc"}, mc1, mc);
        check({name, "_m0_bc"}, bc0, bc);
        check({name, "_m0_mc"}, mc0, mc);
    endtask

    task automatic sb_compare(input int n);
        step_t e;
        string nm;
        nm = $sformatf("step%0d", n);
        if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb_q.pop_front();
            check_lookup(nm, e.hit, e.tkn, e.tgt);
            check_counts(nm, e.bc, e.mc);
        end
    endtask

    // Drive one update at a negedge, then look up after the edge and compare.
    task automatic drive_step(input step_t s, input int n);
        update_valid      = s.uv;
        update_pc         = s.upc;
        update_taken      = s.ut;
        update_target     = s.utgt;
        update_mispredict = s.umis;
        @(posedge clk);
        #1;
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
        lookup_pc         = s.lpc;
        sb_q.push_back(s);
        @(negedge clk);
        sb_compare(n);
    endtask

    // Hold for the whole clear sequence, checking ready stays low and nothing hits.
    task automatic check_init_window(input string name);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            check($sformatf("%s_ready_low%0d", name, i), 32'(ready1), 32'd0);
            check($sformatf("%s_hit_low%0d", name, i), 32'({hit1, hit0}), 32'd0);
            check_counts($sformatf("%s_cnt%0d", name, i), 32'd0, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check({name, "_ready_high"}, 32'({ready1, ready0}), 32'd3);
    endtask

    initial begin
        //            uv    upc        ut    utgt       umis  lpc        hit   tkn   tgt        bc  mc
        steps[0]  = '{1'b1, 32'h100,  1'b1, 32'h200, 1'b1, 32'h100,  1'b1, 1'b1, 32'h200, 1,  1};
        steps[1]  = '{1'b1, 32'h100,  1'b0, 32'h0,   1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 2,  2};
        steps[2]  = '{1'b1, 32'h100,  1'b0, 32'h0,   1'b0, 32'h100,  1'b1, 1'b0, 32'h200, 3,  2};
        steps[3]  = '{1'b1, 32'h100,  1'b0, 32'h0,   1'b0, 32'h100,  1'b1, 1'b0, 32'h200, 4,  2};
        steps[4]  = '{1'b1, 32'h100,  1'b1, 32'h200, 1'b1, 32'h100,  1'b1, 1'b0, 32'h200, 5,  3};
        steps[5]  = '{1'b1, 32'h100,  1'b1, 32'h200, 1'b1, 32'h100,  1'b1, 1'b1, 32'h200, 6,  4};
        steps[6]  = '{1'b1, 32'h100,  1'b1, 32'h240, 1'b0, 32'h100,  1'b1, 1'b1, 32'h240, 7,  4};
        steps[7]  = '{1'b1, 32'h100,  1'b1, 32'h240, 1'b0, 32'h100,  1'b1, 1'b1, 32'h240, 8,  4};
        steps[8]  = '{1'b1, 32'h100,  1'b1, 32'h240, 1'b0, 32'h100,  1'b1, 1'b1, 32'h240, 9,  4};
        steps[9]  = '{1'b1, 32'h100,  1'b0, 32'h0,   1'b1, 32'h100,  1'b1, 1'b1, 32'h240, 10, 5};
        steps[10] = '{1'b1, 32'h4100, 1'b0, 32'h0,   1'b0, 32'h100,  1'b1, 1'b1, 32'h240, 11, 5};
        steps[11] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h4100, 1'b0, 1'b0, 32'h0,   11, 5};
        steps[12] = '{1'b1, 32'h4100, 1'b1, 32'h300, 1'b1, 32'h4100, 1'b1, 1'b1, 32'h300, 12, 6};
        steps[13] = '{1'b0, 32'h0,    1'b0, 32'h0,   1'b0, 32'h100,  1'b0, 1'b0, 32'h0,   12, 6};
        steps[14] = '{1'b0, 32'h4100, 1'b1, 32'h0,   1'b1, 32'h4100, 1'b1, 1'b1, 32'h300, 12, 6};
        steps[15] = '{1'b1, 32'h104,  1'b1, 32'h500, 1'b0, 32'h104,  1'b1, 1'b1, 32'h500, 13, 6};

        reset             = 1'b1;
        lookup_pc         = 32'h100;
        update_valid      = 1'b0;
        update_pc         = '0;
        update_taken      = 1'b0;
        update_target     = '0;
        update_mispredict = 1'b0;

        // Power-on reset: one cycle high, then the clear sequence.
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_init_window("por");

        // Training, saturation, aliasing and update qualification.
        foreach (steps[i]) drive_step(steps[i], i);

        // Read-before-write on a hit: 0x104 not-taken, lookup sees the old counter.
        update_valid = 1'b1; update_pc = 32'h104; update_taken = 1'b0;
        update_target = 32'h0; update_mispredict = 1'b1; lookup_pc = 32'h104;
        #1;
        check_lookup("rbw_hit_pre", 1'b1, 1'b1, 32'h500);
        @(posedge clk);
        #1;
        update_valid = 1'b0; update_mispredict = 1'b0;
        @(negedge clk);
        check_lookup("rbw_hit_post", 1'b1, 1'b0, 32'h500);
        check_counts("rbw_hit_post", 32'd14, 32'd7);

        // Read-before-write on an allocate: 0x108 misses until the edge.
        update_valid = 1'b1; update_pc = 32'h108; update_taken = 1'b1;
        update_target = 32'h600; update_mispredict = 1'b0; lookup_pc = 32'h108;
        #1;
        check_lookup("rbw_alloc_pre", 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        update_valid = 1'b0;
        @(negedge clk);
        check_lookup("rbw_alloc_post", 1'b1, 1'b1, 32'h600);
        check_counts("rbw_alloc_post", 32'd15, 32'd7);

        // Mid-run reset with updates held valid throughout the clear sequence.
        reset = 1'b1; update_valid = 1'b1; update_pc = 32'h100; update_taken = 1'b1;
        update_target = 32'h700; update_mispredict = 1'b1; lookup_pc = 32'h100;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check_init_window("mid");
        update_valid = 1'b0; update_mispredict = 1'b0;
        check_counts("mid_after", 32'd0, 32'd0);
        lookup_pc = 32'h100;  #1; check_lookup("mid_miss_100", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h104;  #1; check_lookup("mid_miss_104", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h108;  #1; check_lookup("mid_miss_108", 1'b0, 1'b0, 32'h0);
        lookup_pc = 32'h4100; #1; check_lookup("mid_miss_4100", 1'b0, 1'b0, 32'h0);
        @(negedge clk);

        // Table trains again after the clear.
        drive_step('{1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h100,
                     1'b1, 1'b1, 32'h200, 1, 0}, 100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
